// File: rtl/fifo_pkg.sv
// Shared defaults and the status bundle for fifo_sync_param.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Contents are deliberately not reset; pointers alone define validity.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, almost thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  Read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] ZERO  = '0;
    localparam logic [ADDR_WIDTH:0] AF_TH = ALMOST_FULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_TH = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  rd_acc;
    logic                  wr_acc;
    fifo_status_t          status;
`ifndef FIFO_FWFT_EN
    logic                  data_valid_q, data_valid_d;
`endif

    // Status depends only on registered pointers, count and flags.
    always_comb begin
        status              = '0;
        status.full         = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                              (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        status.empty        = (wr_ptr_q == rd_ptr_q);
        status.almost_full  = (count_q >= AF_TH);
        status.almost_empty = (count_q <= AE_TH);
        status.overflow     = overflow_q;
        status.underflow    = underflow_q;
    end

    always_comb begin
        rd_acc      = Read_enable && !status.empty;
        // A pop in the same cycle frees the slot a write into a full FIFO needs.
        wr_acc      = Wr_enable && (!status.full || rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (Wr_enable && !wr_acc);
        underflow_d = underflow_q | (Read_enable && !rd_acc);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

`ifdef FIFO_FWFT_EN
    // Read-ahead register tracks the head entry as it will be after this edge;
    // when that head is the word being written now, bypass the array.
    assign mem_rd_addr = rd_ptr_d[ADDR_WIDTH-1:0];

    always_comb begin
        data_out_d = mem_rd_data;
        if (wr_acc && ((count_q == ZERO) || ((count_q == ONE) && rd_acc))) begin
            data_out_d = data_in;
        end
    end

    assign data_valid = !status.empty;
`else
    assign mem_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = rd_acc;
        if (rd_acc) begin
            data_out_d = mem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= data_valid_d;
        end
    end

    assign data_valid = data_valid_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            data_out_q  <= data_out_d;
        end
    end

    // Reset must not write the array, so the write enable is gated here.
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !reset),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

    assign data_out     = data_out_q;
    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised scoreboard bench for fifo_sync_param (DEPTH=8, thresholds 6/2).
module tb_fifo_sync_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] dout;
    logic          dvalid;
    logic          full, empty, afull, aempty, ovf, unf;
    logic [AW:0]   cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, plain occupancy rules.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_hold = '0;
    logic          exp_valid = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic          model_live = 1'b0;

    fifo_sync_param #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .ALMOST_FULL_TH  (AF),
        .ALMOST_EMPTY_TH (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Wr_enable    (wr_en),
        .data_in      (din),
        .Read_enable  (rd_en),
        .data_out     (dout),
        .data_valid   (dvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (afull),
        .almost_empty (aempty),
        .count        (cnt),
        .overflow     (ovf),
        .underflow    (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic do_rd;
        logic do_wr;
        logic [DW-1:0] v;
        if (reset) begin
            mq.delete();
            exp_q.delete();
            exp_hold   = '0;
            exp_valid  = 1'b0;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            do_rd = rd_en && (mq.size() > 0);
            do_wr = wr_en && ((mq.size() < DEPTH) || do_rd);
            if (rd_en && !do_rd) m_unf = 1'b1;
            if (wr_en && !do_wr) m_ovf = 1'b1;
            exp_valid = 1'b0;
            if (do_rd) begin
                v = mq.pop_front();
`ifndef FIFO_FWFT_EN
                exp_q.push_back(v);
                exp_hold  = v;
                exp_valid = 1'b1;
`endif
            end
            if (do_wr) mq.push_back(din);
        end
    end

    // Monitor: compares DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        int n;
        if (model_live) begin
            n = mq.size();
            chk("count", 32'(cnt), 32'(n));
            chk("full", 32'(full), 32'(n == DEPTH));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("almost_full", 32'(afull), 32'(n >= AF));
            chk("almost_empty", 32'(aempty), 32'(n <= AE));
            chk("overflow", 32'(ovf), 32'(m_ovf));
            chk("underflow", 32'(unf), 32'(m_unf));
`ifdef FIFO_FWFT_EN
            chk("data_valid", 32'(dvalid), 32'(n != 0));
            if (dvalid && n != 0) chk("fwft_head", 32'(dout), 32'(mq[0]));
`else
            chk("data_valid", 32'(dvalid), 32'(exp_valid));
            if (dvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    chk("read_data", 32'(dout), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("data_hold", 32'(dout), 32'(exp_hold));
            end
`endif
        end
    end

    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic rst);
        @(posedge clk);
        #1;
        wr_en = w;
        din   = d;
        rd_en = r;
        reset = rst;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        // Fill then overflow
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
        drive(1'b1, 8'h09, 1'b0, 1'b0);
        // Drain then underflow
        for (int i = 0; i < 9; i++) drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        // Full with simultaneous read+write
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0);
        // Empty with simultaneous read+write
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        // Wrap-around with 3 in flight
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, DW'($urandom_range(0, 255)), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
        // Reset mid-stream with a concurrent write
        for (int i = 0; i < 5; i++) drive(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        // FWFT-style single write into empty, read two cycles later
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        // Randomised traffic with rare resets
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 55, DW'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < 50, $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 12; i++) drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pending_reads", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO, the successor to the team's first-generation single-clock FIFO. All 2**ADDR_WIDTH entries are usable, and it reports an occupancy count. It adds almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and an optional first-word-fall-through (FWFT) read mode. It sits between any producer and consumer in the same clock domain.

## Interface
Parameters:
- DATA_WIDTH, 8: width of each entry in bits.
- ADDR_WIDTH, 5: pointer width. Depth DEPTH = 2**ADDR_WIDTH.
- ALMOST_FULL_TH, DEPTH-2: `almost_full` asserts when count >= this. Legal range 1..DEPTH.
- ALMOST_EMPTY_TH, 2: `almost_empty` asserts when count <= this. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Wr_enable  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- Read_enable  in  1  read request (pop).
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  `data_out` is valid (meaning depends on mode).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL_TH.
- almost_empty  out  1  count <= ALMOST_EMPTY_TH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- Pointers are ADDR_WIDTH+1 bits wide. The MSB is a wrap bit.
- `full` = (addresses equal and wrap bits differ).
- `empty` = (pointers equal).
- Both pointers wrap naturally modulo 2*DEPTH.
- `rd_acc` = Read_enable && !empty.
- `wr_acc` = Wr_enable && (!full || rd_acc).
  - When full, a simultaneous accepted read frees a slot, so the write is also accepted.
- When empty, a simultaneous read and write: the read is rejected (underflow sets), the write is accepted, and count becomes 1.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither occur.
- All status outputs derive from registered pointers and count, with no combinational path from inputs.
- `overflow` sets when Wr_enable && !wr_acc. `underflow` sets when Read_enable && !rd_acc. Both hold until reset.
- The memory array is not cleared on reset. Only the pointers, count, flags and `data_out` are reset.
- Reset is synchronous. It overrides any simultaneous read or write, and a reset asserted mid-stream discards all contents.

## Timing
Reset values:
- `data_out` = 0, `data_valid` = 0.
- `empty` = 1, `full` = 0, `count` = 0.
- `almost_empty` = 1, `almost_full` = 0.
- `overflow` = 0, `underflow` = 0.

Latency and flag timing:
- Write accepted at edge N: count and flags update after edge N. The entry is readable from cycle N+1.
- Standard mode read: with rd_acc at edge N, `data_out` holds the head entry and `data_valid` = 1 for the cycle after edge N. Otherwise `data_valid` = 0 and `data_out` holds its previous value.
- Full-to-not-full and empty-to-not-empty transitions occur one cycle after the causing edge.

## Configuration
- Macro `FIFO_FWFT_EN`.
- Defined:
  - `data_out` continuously shows the head entry (registered read-ahead).
  - `data_valid` = !empty.
  - A write into an empty FIFO at edge N makes `data_out`/`data_valid` valid after edge N.
  - Read_enable pops the head. The next entry appears after that edge.
  - `data_out` is don't-care while `data_valid` = 0.
- Undefined: standard registered-read behaviour as described in Timing.
- Flag, count and error semantics are identical in both modes.

## Structure
- Package `fifo_pkg`:
  - default DATA_WIDTH/ADDR_WIDTH constants.
  - typedef `fifo_status_t`, a struct of full, empty, almost_full, almost_empty, overflow, underflow.
- Sub-module `fifo_mem`:
  - DEPTH x DATA_WIDTH dual-port array.
  - Synchronous write port, asynchronous read port.
  - Instantiated once. The top holds pointers, count, flags and the output register.

## Test plan
Use DATA_WIDTH=8, ADDR_WIDTH=3 (DEPTH=8), ALMOST_FULL_TH=6, ALMOST_EMPTY_TH=2 unless stated.
- Fill: write 0x01..0x08 on consecutive cycles -> count 1..8, `almost_full` at count 6, `full` after the 8th write, no overflow. A 9th write -> `overflow`=1, count stays 8.
- Drain: read 8 times -> `data_out` 0x01..0x08 each with `data_valid` pulse. `empty` after the last read. A 9th read -> `underflow`=1, `data_out` unchanged.
- Simultaneous access:
  - Full plus read+write of 0xAA -> count stays 8, no overflow, 0xAA is read out last.
  - Empty plus read+write -> count 1, `underflow`=1.
- Wrap-around: 20 write/read pairs with 3 entries in flight -> data order preserved across pointer wrap, count stays 3.
- Reset mid-operation: with count 5, assert reset for one cycle together with Wr_enable -> count 0, `empty`=1, flags cleared, and the next read returns the next newly written value.
- FWFT build: write 0x5A into empty at edge N -> `data_valid`=1 and `data_out`=0x5A after N with no read. Read_enable at N+2 -> `empty`=1 and `data_valid`=0 after that edge.
